// File: rtl/fadd_seq_if.sv
// -----------------------------------------------------------------------------
// fadd_seq_if
// Operand/result bundle for the sequential FP32 magnitude adder.
//
// Signals
//   in_valid  : operands a/b are valid                      (master -> slave)
//   in_ready  : adder can take operands                     (slave  -> master)
//   a, b      : FP32 operands                               (master -> slave)
//   out_valid : result/overflow/inexact are valid           (slave  -> master)
//   out_ready : consumer takes the result                   (master -> slave)
//   result    : FP32 sum, sign taken from a                 (slave  -> master)
//   overflow  : finite inputs rounded to infinity           (slave  -> master)
//   inexact   : precision was discarded                     (slave  -> master)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; ready may be asserted without valid, and a transfer never happens on
// ready alone.
// -----------------------------------------------------------------------------
interface fadd_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        inexact;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, overflow, inexact
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, overflow, inexact
   );
endinterface

// File: rtl/fadd_seq.sv
// -----------------------------------------------------------------------------
// fadd_seq
// Sequential IEEE-754 single-precision magnitude adder: result = |a| + |b|
// with the sign of a. The smaller operand is aligned one bit per cycle, the
// sum is normalised on carry-out and rounded to nearest-even.
//
// Ports
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : fadd_seq_if.slave (operand and result handshakes, flags)
//   o_state : current FSM state (debug)
//
// Latency from the accept edge to out_valid: 3 + min(d, MAX_ALIGN) cycles for
// ordinary operands, 1 cycle for NaN/infinity/zero operands.
// -----------------------------------------------------------------------------
module fadd_seq #(
   parameter int MAX_ALIGN = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   fadd_seq_if.slave  bus,
   output logic [2:0] o_state
);

   localparam int CW = $clog2(MAX_ALIGN + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ALIGN = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    r_state;
   logic          r_sign;
   logic [8:0]    r_exp;      // one spare bit so exponent overflow is visible
   logic [26:0]   r_big;      // {mantissa[23:0], guard, round, sticky}
   logic [26:0]   r_small;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_result;
   logic          r_overflow;
   logic          r_inexact;

   // ---------------- accept-time decode of the incoming operands -------------
   logic [7:0]    w_ea, w_eb, w_e_big, w_e_small, w_d;
   logic          w_b_big;
   logic [23:0]   w_m_big, w_m_small;
   logic [CW-1:0] w_d_cap;
   logic          w_special;
   logic [31:0]   w_spec_res;
   logic          w_unused_b_sign;

   // The sign of b never matters: only equal-sign pairs are routed here.
   assign w_unused_b_sign = bus.b[31];

   assign w_ea      = bus.a[30:23];
   assign w_eb      = bus.b[30:23];
   assign w_b_big   = (w_eb > w_ea);   // equal exponents keep a as big
   assign w_e_big   = w_b_big ? w_eb : w_ea;
   assign w_e_small = w_b_big ? w_ea : w_eb;
   assign w_m_big   = w_b_big ? {1'b1, bus.b[22:0]} : {1'b1, bus.a[22:0]};
   assign w_m_small = w_b_big ? {1'b1, bus.a[22:0]} : {1'b1, bus.b[22:0]};
   assign w_d       = w_e_big - w_e_small;
   // Past MAX_ALIGN shifts the small mantissa is already folded into sticky.
   assign w_d_cap   = (w_d > 8'(MAX_ALIGN)) ? CW'(MAX_ALIGN) : w_d[CW-1:0];

   always_comb begin
      w_special  = 1'b1;
      w_spec_res = 32'h7FC0_0000;
      if ((w_ea == 8'hFF && bus.a[22:0] != 23'd0) ||
          (w_eb == 8'hFF && bus.b[22:0] != 23'd0)) begin
         w_spec_res = 32'h7FC0_0000;
      end else if (w_ea == 8'hFF || w_eb == 8'hFF) begin
         w_spec_res = {bus.a[31], 8'hFF, 23'd0};
      end else if (w_ea == 8'd0 && w_eb == 8'd0) begin
         w_spec_res = {bus.a[31], 31'd0};
      end else if (w_ea == 8'd0) begin
         // denormal/zero a is flushed; b passes through under a's sign
         w_spec_res = {bus.a[31], bus.b[30:0]};
      end else if (w_eb == 8'd0) begin
         w_spec_res = bus.a;
      end else begin
         w_special = 1'b0;
      end
   end

   // ---------------- add and round datapath ----------------------------------
   logic [27:0] w_sum;
   logic        w_guard, w_rs, w_inc, w_rnd_c, w_ovf;
   logic [22:0] w_frac_rnd;
   logic [8:0]  w_e_rnd;

   assign w_sum   = {1'b0, r_big} + {1'b0, r_small};
   assign w_guard = r_big[2];
   assign w_rs    = r_big[1] | r_big[0];
   assign w_inc   = w_guard & (w_rs | r_big[3]);   // ties go to even
   // A carry out of the 23-bit fraction means the mantissa rounded up to 2.0:
   // the fraction wraps to zero and the exponent takes the carry.
   assign {w_rnd_c, w_frac_rnd} = {1'b0, r_big[25:3]} + {23'd0, w_inc};
   assign w_e_rnd = r_exp + {8'd0, w_rnd_c};
   assign w_ovf   = (w_e_rnd >= 9'd255);

   // ---------------- control -------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_sign     <= 1'b0;
         r_exp      <= 9'd0;
         r_big      <= 27'd0;
         r_small    <= 27'd0;
         r_cnt      <= '0;
         r_result   <= 32'd0;
         r_overflow <= 1'b0;
         r_inexact  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_sign <= bus.a[31];
                  if (w_special) begin
                     r_result   <= w_spec_res;
                     r_overflow <= 1'b0;
                     r_inexact  <= 1'b0;
                     r_state    <= S_DONE;
                  end else begin
                     r_exp   <= {1'b0, w_e_big};
                     r_big   <= {w_m_big, 3'b000};
                     r_small <= {w_m_small, 3'b000};
                     r_cnt   <= w_d_cap;
                     r_state <= (w_d == 8'd0) ? S_ADD : S_ALIGN;
                  end
               end
            end
            S_ALIGN: begin
               // bit 0 is sticky: it absorbs whatever falls off the right
               r_small <= {1'b0, r_small[26:2], r_small[1] | r_small[0]};
               r_cnt   <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_ADD;
               end
            end
            S_ADD: begin
               if (w_sum[27]) begin
                  r_big <= {w_sum[27:2], w_sum[1] | w_sum[0]};
                  r_exp <= r_exp + 9'd1;
               end else begin
                  r_big <= w_sum[26:0];
               end
               r_state <= S_ROUND;
            end
            S_ROUND: begin
               if (w_ovf) begin
                  r_result   <= {r_sign, 8'hFF, 23'd0};
                  r_overflow <= 1'b1;
               end else begin
                  r_result   <= {r_sign, w_e_rnd[7:0], w_frac_rnd};
                  r_overflow <= 1'b0;
               end
               // infinity is never the exact sum, so overflow is also inexact
               r_inexact <= w_guard | w_rs | w_ovf;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.result    = r_result;
   assign bus.overflow  = r_overflow;
   assign bus.inexact   = r_inexact;
   assign o_state       = r_state;

endmodule

// File: tb/tb_fadd_seq.sv
// -----------------------------------------------------------------------------
// tb_fadd_seq
// Self-checking bench for fadd_seq. Expected sums come from an exact-integer
// model of |a|+|b| rounded to nearest-even.
// -----------------------------------------------------------------------------
module tb_fadd_seq;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fadd_seq_if bus_if();
   logic [2:0] dbg_state;

   fadd_seq #(.MAX_ALIGN(26)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus_if),
      .o_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard: {overflow, inexact, result} and expected latency
   logic [33:0] exp_q[$];
   int          lat_q[$];
   logic [31:0] last_result;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Exact integer sum of the two mantissas at the smaller exponent, then
   // round-to-nearest-even on the exact remainder.
   function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           output int lat);
      int ea, eb, eg, es, d, p, sh, e;
      longint unsigned mg, ms, s, m, rem, half;
      logic inx;
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      lat = 1;
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0))
         return {2'b00, 32'h7FC0_0000};
      if (ea == 255 || eb == 255) return {2'b00, a[31], 8'hFF, 23'd0};
      if (ea == 0 && eb == 0)     return {2'b00, a[31], 31'd0};
      if (ea == 0)                return {2'b00, a[31], b[30:0]};
      if (eb == 0)                return {2'b00, a[31], a[30:0]};
      if (eb > ea) begin
         eg = eb; es = ea;
         mg = {40'd0, 1'b1, b[22:0]};
         ms = {40'd0, 1'b1, a[22:0]};
      end else begin
         eg = ea; es = eb;
         mg = {40'd0, 1'b1, a[22:0]};
         ms = {40'd0, 1'b1, b[22:0]};
      end
      d   = eg - es;
      lat = 3 + ((d > 26) ? 26 : d);
      // the small operand is below a quarter ulp of big: big survives, inexact
      if (d > 26) return {2'b01, a[31], eg[7:0], mg[22:0]};
      s = (mg << d) + ms;
      p = 0;
      for (int i = 0; i < 64; i++) if (s[i]) p = i;
      sh   = p - 23;
      m    = s >> sh;
      rem  = s & ((64'd1 << sh) - 64'd1);
      half = (sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
      e    = es + sh;
      if (sh > 0 && (rem > half || (rem == half && m[0]))) m = m + 64'd1;
      if (m == (64'd1 << 24)) begin
         m = m >> 1;
         e = e + 1;
      end
      inx = (rem != 64'd0);
      if (e >= 255) return {2'b11, a[31], 8'hFF, 23'd0};
      return {1'b0, inx, a[31], e[7:0], m[22:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int          lat;
      logic [33:0] e;
      e = ref_add(a, b, lat);
      exp_q.push_back(e);
      lat_q.push_back(lat);
      @(negedge clk);
      check("in_ready_idle", 32'(bus_if.in_ready), 32'd1);
      bus_if.in_valid = 1'b1;
      bus_if.a        = a;
      bus_if.b        = b;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
   endtask

   // Waits for the result, checks it, optionally holds it under backpressure
   // while pulsing in_valid, then completes the output handshake.
   task automatic collect(input string tag, input int hold);
      int          lat;
      int          exp_lat;
      logic [33:0] e;
      e       = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      lat     = 1;
      while (bus_if.out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"},  lat, exp_lat);
      check({tag, "_result"},   bus_if.result, e[31:0]);
      check({tag, "_overflow"}, 32'(bus_if.overflow), 32'(e[33]));
      check({tag, "_inexact"},  32'(bus_if.inexact), 32'(e[32]));
      last_result = bus_if.result;
      for (int i = 0; i < hold; i++) begin
         bus_if.in_valid = 1'b1;
         bus_if.a        = $urandom;
         bus_if.b        = $urandom;
         @(posedge clk);
         #1;
         check({tag, "_hold_result"},    bus_if.result, e[31:0]);
         check({tag, "_hold_in_ready"},  32'(bus_if.in_ready), 32'd0);
         check({tag, "_hold_out_valid"}, 32'(bus_if.out_valid), 32'd1);
      end
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.out_ready = 1'b0;
      check({tag, "_drain_out_valid"}, 32'(bus_if.out_valid), 32'd0);
      check({tag, "_drain_in_ready"},  32'(bus_if.in_ready), 32'd1);
   endtask

   // ---------------- directed vectors ----------------
   logic [31:0] dir_a[9] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h3F80_0001,
                             32'h3F80_0000, 32'h7F7F_FFFF, 32'hBF80_0000,
                             32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000};
   logic [31:0] dir_b[9] = '{32'h3F80_0000, 32'h3F40_0000, 32'h3380_0000,
                             32'h3080_0000, 32'h7F7F_FFFF, 32'hBF80_0000,
                             32'h3F80_0000, 32'h3F80_0000, 32'h4049_0FDB};
   logic [31:0] dir_r[9] = '{32'h4000_0000, 32'h4010_0000, 32'h3F80_0002,
                             32'h3F80_0000, 32'h7F80_0000, 32'hC000_0000,
                             32'h7FC0_0000, 32'h7F80_0000, 32'h4049_0FDB};

   // ---------------- stimulus ----------------
   initial begin
      bus_if.in_valid  = 1'b0;
      bus_if.a         = 32'd0;
      bus_if.b         = 32'd0;
      bus_if.out_ready = 1'b0;
      last_result      = 32'd0;
      rst_n            = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready",  32'(bus_if.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
      check("reset_result",    bus_if.result, 32'd0);
      check("reset_overflow",  32'(bus_if.overflow), 32'd0);
      check("reset_inexact",   32'(bus_if.inexact), 32'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 9; k++) begin
         send(dir_a[k], dir_b[k]);
         collect($sformatf("dir%0d", k), 0);
         check($sformatf("dir%0d_const", k), last_result, dir_r[k]);
      end

      // backpressure: result held for 5 cycles, in_valid pulses ignored
      send(32'h3FC0_0000, 32'h3F40_0000);
      collect("backpressure", 5);
      check("backpressure_const", last_result, 32'h4010_0000);

      // reset in the middle of a 20-step alignment
      send(32'h3F80_0000, 32'h3580_0000);
      void'(exp_q.pop_back());
      void'(lat_q.pop_back());
      repeat (5) @(posedge clk);
      #1;
      check("mid_align_busy", 32'(bus_if.in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_reset_out_valid", 32'(bus_if.out_valid), 32'd0);
      check("mid_reset_in_ready",  32'(bus_if.in_ready), 32'd1);
      check("mid_reset_result",    bus_if.result, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(32'h3F80_0000, 32'h3580_0000);
      collect("after_reset", 0);

      // randomised equal-sign pairs, close and far exponents, some specials
      for (int k = 0; k < 40; k++) begin
         logic        s;
         int          ea, eb;
         logic [31:0] ra, rb;
         s  = 1'($urandom_range(0, 1));
         ea = int'($urandom_range(1, 254));
         eb = ea + int'($urandom_range(0, 64)) - 32;
         if (eb < 1)   eb = 1;
         if (eb > 254) eb = 254;
         if (k % 8 == 3) begin
            ea = 254;
            eb = 254 - int'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 9) == 0) eb = ($urandom_range(0, 1) == 1) ? 0 : 255;
         ra = {s, ea[7:0], 23'($urandom)};
         rb = {s, eb[7:0], 23'($urandom)};
         if (k % 2 == 1) begin
            send(rb, ra);
         end else begin
            send(ra, rb);
         end
         collect($sformatf("rand%0d", k), int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fadd_seq.md
Name: fadd_seq

Overview:
Sequential IEEE-754 single-precision magnitude adder: the effective-addition counterpart of the combinational mantissa subtractor in the FP add/sub datapath. Accepts two FP32 operands over a valid/ready handshake and computes |a|+|b| with the sign of a. Alignment is iterative, one bit per cycle. The result is normalized (carry-out right shift), rounded RNE, and returned over a valid/ready handshake. The top-level dispatcher sends equal-sign operand pairs here and different-sign pairs to the subtractor.

Parameters:
MAX_ALIGN, 26, cap on alignment shift cycles; larger exponent differences collapse the smaller mantissa into sticky.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  32  FP32 operand A (sign, exp[7:0], frac[22:0])
b  input  32  FP32 operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  32  FP32 sum, sign = a[31]
overflow  output  1  result rounded to infinity from finite inputs
inexact  output  1  any nonzero guard/round/sticky bit was discarded

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0, result=0, overflow=0, inexact=0; all internal regs 0. Reset mid-operation discards the operation immediately.
- Accept: on a clk edge with in_valid&in_ready. Latch operands. Swap so that the operand with the larger exponent is "big"; on equal exponents, a is big.
- Mantissas are 24 bits (implicit 1), extended with guard/round/sticky to 27 bits. d = e_big - e_small (8-bit unsigned).
- Special bypass, evaluated at accept; next state is DONE (out_valid 1 cycle after accept):
  - either exp==255 with nonzero frac -> 0x7FC00000;
  - else either exp==255 -> {a[31],0xFF,0};
  - else either exp==0 (zero/denormal, flushed) -> other operand with sign a[31], frac kept; both zero -> {a[31],31'b0}.
- States:
  - IDLE -> ALIGN if d>0, ADD if d==0, DONE if special.
  - ALIGN: shift small right 1/cycle, OR shifted-out bit into sticky, decrement counter. Counter loads min(d,MAX_ALIGN). If d>MAX_ALIGN, after MAX_ALIGN cycles small is all-sticky. Exit to ADD when counter==0.
  - ADD: 28-bit sum = big+small. If carry, shift right 1 with sticky OR and exp+1. -> ROUND.
  - ROUND: RNE on guard/(round|sticky)/LSB. Mantissa round carry -> exp+1, frac=0. exp>=255 -> {a[31],0xFF,0}, overflow=1. inexact = guard|round|sticky. -> DONE.
  - DONE: out_valid=1; result/flags held stable until out_valid&out_ready, then -> IDLE (out_valid=0 next cycle). No new accept in the same cycle.
- Latency, accept edge to out_valid high: 3+min(d,MAX_ALIGN) cycles normal path; 1 cycle special path.
- in_ready=0 in every state except IDLE. out_ready is ignored outside DONE.
- Flags are updated only when entering DONE.

Test Plan:
- 0x3F800000+0x3F800000 (d=0) -> result 0x40000000, out_valid 3 cycles after accept, overflow=0, inexact=0.
- 0x3FC00000+0x3F400000 (d=1) -> 0x40100000 after 4 cycles; 0x3F800001+0x33800000 (d=24, tie, odd LSB) -> 0x3F800002, inexact=1, 27 cycles.
- 0x3F800000+0x30800000 (d=30) -> ALIGN capped at 26 cycles, result 0x3F800000, inexact=1, out_valid after 29 cycles.
- 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1; 0xBF800000+0xBF800000 -> 0xC0000000.
- Specials: 0x7FC00000+0x3F800000 -> 0x7FC00000 after 1 cycle; 0x7F800000+0x3F800000 -> 0x7F800000; 0x00000000+0x40490FDB -> 0x40490FDB.
- Backpressure and reset: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, in_valid pulses ignored. Assert rst_n=0 mid-ALIGN -> immediately IDLE, out_valid=0, result=0. A new operation after reset completes correctly.
